frame_read_driver: RTL and testbench

- Parametrised successor to the fixed three-word mouse packet reader.
- Parses a byte stream from the SPART receiver: 2-byte sync header, then NUM_WORDS 16-bit words sent MSB first.
- Payload collects in a shadow buffer and is committed atomically to a CPU-visible register bank, read by address.
- Adds inter-byte timeout, resync on a repeated sync byte, and frame/error counters.

---
 rtl/frame_read_pkg.sv | 26 ++
 rtl/frame_timeout_ctr.sv | 30 +++
 rtl/frame_read_driver.sv | 177 +++++++++++++++++
 tb/tb_frame_read_driver.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_read_pkg.sv
// Shared definitions for the framed SPART reader: parser states, default sync bytes,
// status-word layout and a saturating counter helper.
package frame_read_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SYNC   = 3'd1,
        HI     = 3'd2,
        LO     = 3'd3,
        CHK    = 3'd4,
        COMMIT = 3'd5
    } state_t;

    localparam logic [7:0] DEF_SYNC0 = 8'hBA;
    localparam logic [7:0] DEF_SYNC1 = 8'h11;

    // Status word read at addr == NUM_WORDS: {frame_cnt, err_cnt}
    localparam int STAT_FIELD_W   = 8;
    localparam int STAT_FRAME_LSB = 8;
    localparam int STAT_ERR_LSB   = 0;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/frame_timeout_ctr.sv
// Inter-byte watchdog: reloads on clear, counts down while run is high and flags
// expire on the idle cycle that reaches CYCLES. CYCLES == 0 disables it.
module frame_timeout_ctr #(
    parameter int CYCLES = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LOAD = (CYCLES > 0) ? W'(CYCLES - 1) : '0;

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= LOAD;
        end else if (run && (count_reg != '0)) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign expire = (CYCLES != 0) && run && !clear && (count_reg == '0);

endmodule

// File: rtl/frame_read_driver.sv
// Framed SPART packet reader: sync header, NUM_WORDS MSB-first words, atomic commit to
// a CPU-readable bank. Optional trailing checksum byte under FRAME_READ_CHECKSUM_EN.
module frame_read_driver
    import frame_read_pkg::*;
#(
    parameter int         NUM_WORDS   = 3,
    parameter logic [7:0] SYNC0       = DEF_SYNC0,
    parameter logic [7:0] SYNC1       = DEF_SYNC1,
    parameter int         TIMEOUT_CYC = 65535,
    parameter int         ADDR_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rda,
    input  logic [7:0]        data_in,
    input  logic [ADDR_W-1:0] addr,
    output logic [15:0]       data_out,
    output logic              frame_done,
    output logic              frame_err
);

    localparam int IDX_W = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [15:0] shadow [NUM_WORDS];
    logic [15:0] bank   [NUM_WORDS];
    logic [7:0]  frame_cnt_reg, err_cnt_reg;
    logic        frame_done_reg, frame_err_reg;
    logic        commit, fail, active, expire, hi_wr, lo_wr;

    assign active = (state_reg == SYNC) || (state_reg == HI) ||
                    (state_reg == LO)   || (state_reg == CHK);
    assign hi_wr  = rda && (state_reg == HI);
    assign lo_wr  = rda && (state_reg == LO);

    frame_timeout_ctr #(.CYCLES(TIMEOUT_CYC)) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (rda || !active),
        .run    (active),
        .expire (expire)
    );

`ifdef FRAME_READ_CHECKSUM_EN
    logic [7:0] sum_reg;
    logic       sum_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg <= '0;
        end else if (rda && (state_reg == SYNC)) begin
            sum_reg <= '0;
        end else if (hi_wr || lo_wr) begin
            sum_reg <= sum_reg + data_in;
        end
    end

    assign sum_ok = (data_in == sum_reg);
`endif

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        commit     = 1'b0;
        fail       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rda && (data_in == SYNC0)) state_next = SYNC;
            end
            SYNC: begin
                if (rda) begin
                    if (data_in == SYNC1) begin
                        state_next = HI;
                        idx_next   = '0;
                    end else if (data_in != SYNC0) begin
                        state_next = IDLE;
                    end
                end
            end
            HI: begin
                if (rda) state_next = LO;
            end
            LO: begin
                if (rda) begin
                    if (idx_reg != LAST_IDX) begin
                        idx_next   = idx_reg + IDX_W'(1);
                        state_next = HI;
                    end else begin
`ifdef FRAME_READ_CHECKSUM_EN
                        state_next = CHK;
`else
                        state_next = COMMIT;
`endif
                    end
                end
            end
            CHK: begin
`ifdef FRAME_READ_CHECKSUM_EN
                if (rda) begin
                    if (sum_ok) begin
                        state_next = COMMIT;
                    end else begin
                        state_next = IDLE;
                        fail       = 1'b1;
                    end
                end
`else
                state_next = IDLE;
`endif
            end
            COMMIT: begin
                // A byte landing in the commit cycle is parsed as if already in IDLE
                commit     = 1'b1;
                state_next = (rda && (data_in == SYNC0)) ? SYNC : IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (expire) begin
            state_next = IDLE;
            fail       = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            frame_cnt_reg  <= '0;
            err_cnt_reg    <= '0;
            frame_done_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                shadow[i] <= '0;
                bank[i]   <= '0;
            end
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            frame_done_reg <= commit;
            frame_err_reg  <= fail;
            if (commit) frame_cnt_reg <= frame_cnt_reg + 8'd1;
            if (fail)   err_cnt_reg   <= sat_inc8(err_cnt_reg);
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (hi_wr && (idx_reg == IDX_W'(i))) shadow[i][15:8] <= data_in;
                if (lo_wr && (idx_reg == IDX_W'(i))) shadow[i][7:0]  <= data_in;
                if (commit) bank[i] <= shadow[i];
            end
        end
    end

    assign frame_done = frame_done_reg;
    assign frame_err  = frame_err_reg;

    logic [NUM_WORDS-1:0] word_hit;
    logic [15:0]          status_word;

    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_hit
        assign word_hit[gi] = (addr == ADDR_W'(gi));
    end

    always_comb begin
        status_word = '0;
        status_word[STAT_FRAME_LSB +: STAT_FIELD_W] = frame_cnt_reg;
        status_word[STAT_ERR_LSB   +: STAT_FIELD_W] = err_cnt_reg;
    end

    always_comb begin
        data_out = 16'h0000;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (word_hit[i]) data_out = bank[i];
        end
        if (addr == ADDR_W'(NUM_WORDS)) data_out = status_word;
    end

endmodule

// File: tb/tb_frame_read_driver.sv
// Self-checking bench for frame_read_driver: scenario table, hand-written latency,
// atomicity, commit-cycle and reset sequences, then randomized frames vs a frame-level model.
module tb_frame_read_driver;

    localparam int NW  = 3;
    localparam int TMO = 20;
    localparam int AW  = 4;

    localparam int K_GOOD   = 0;
    localparam int K_RESYNC = 1;
    localparam int K_JUNK   = 2;
    localparam int K_TMO    = 3;
    localparam int K_BADCK  = 4;

    typedef logic [NW-1:0][15:0] words_t;

    typedef struct {
        int     kind;
        words_t words;
        int     exp_done;
        int     exp_err;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rda = 1'b0;
    logic [7:0]    data_in = 8'h00;
    logic [AW-1:0] addr = '0;
    logic [15:0]   data_out;
    logic          frame_done, frame_err;

    frame_read_driver #(
        .NUM_WORDS   (NW),
        .SYNC0       (8'hBA),
        .SYNC1       (8'h11),
        .TIMEOUT_CYC (TMO),
        .ADDR_W      (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rda        (rda),
        .data_in    (data_in),
        .addr       (addr),
        .data_out   (data_out),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int err_seen = 0;
    bit no_gap = 1'b0;

    // Frame-level reference model
    logic [15:0] m_bank [NW];
    int m_frames = 0;
    int m_errs = 0;
    int m_done_total = 0;
    int m_err_total = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_done === 1'b1) done_seen++;
            if (frame_err === 1'b1) err_seen++;
        end
    end

    function automatic words_t mk(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        words_t w;
        w[0] = a;
        w[1] = b;
        w[2] = c;
        return w;
    endfunction

    function automatic logic [15:0] exp_read(input int a);
        logic [7:0] f, e;
        f = m_frames[7:0];
        e = m_errs[7:0];
        if (a < NW) return m_bank[a];
        if (a == NW) return {f, e};
        return 16'h0000;
    endfunction

    task automatic check16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic gap();
        if (!no_gap) idle($urandom_range(0, 3));
    endtask

    task automatic send_byte(input logic [7:0] b);
        rda = 1'b1;
        data_in = b;
        @(negedge clk);
        rda = 1'b0;
        data_in = 8'($urandom);
    endtask

    task automatic send_payload(input words_t w, input bit bad);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < NW; i++) begin
            gap();
            send_byte(w[i][15:8]);
            gap();
            send_byte(w[i][7:0]);
            s = s + w[i][15:8] + w[i][7:0];
        end
        s = bad ? s + 8'd1 : s;
`ifdef FRAME_READ_CHECKSUM_EN
        gap();
        send_byte(s);
`endif
    endtask

    task automatic model_apply(input words_t w, input int ndone, input int nerr);
        if (ndone > 0) begin
            for (int i = 0; i < NW; i++) m_bank[i] = w[i];
            m_frames = (m_frames + ndone) % 256;
            m_done_total += ndone;
        end
        if (nerr > 0) begin
            m_errs = (m_errs + nerr > 255) ? 255 : m_errs + nerr;
            m_err_total += nerr;
        end
    endtask

    task automatic check_reads(input string tag);
        for (int a = 0; a <= NW + 1; a++) begin
            addr = AW'(a);
            #1;
            check16($sformatf("%s_rd%0d", tag, a), data_out, exp_read(a));
        end
        addr = AW'(15);
        #1;
        check16($sformatf("%s_rd15", tag), data_out, exp_read(15));
        @(negedge clk);
    endtask

    task automatic run_scenario(input int kind, input words_t w);
        int k;
        if (kind == K_RESYNC) begin
            send_byte(8'hBA); gap(); send_byte(8'hBA); gap(); send_byte(8'h11);
            send_payload(w, 1'b0);
        end else if (kind == K_JUNK) begin
            send_byte(8'hBA); gap(); send_byte(8'h55); gap();
            send_byte(8'hBA); gap(); send_byte(8'h11);
            send_payload(w, 1'b0);
        end else if (kind == K_TMO) begin
            send_byte(8'hBA); gap(); send_byte(8'h11);
            k = $urandom_range(0, 2 * NW - 1);
            for (int i = 0; i < k; i++) begin
                gap();
                send_byte(8'($urandom));
            end
            idle(TMO + 2);
        end else begin
            send_byte(8'hBA); gap(); send_byte(8'h11);
            send_payload(w, kind == K_BADCK);
        end
        idle(3);
    endtask

    task automatic apply_and_check(input string tag, input int kind, input words_t w,
                                   input int exp_done, input int exp_err);
        int d0, e0;
        d0 = done_seen;
        e0 = err_seen;
        run_scenario(kind, w);
        #1;
        check_int({tag, "_done"}, done_seen - d0, exp_done);
        check_int({tag, "_err"}, err_seen - e0, exp_err);
        model_apply(w, exp_done, exp_err);
        $display("txn %s kind=%0d words=%h done=%0d err=%0d", tag, kind, w, done_seen - d0, err_seen - e0);
        check_reads(tag);
    endtask

    vec_t tbl[$];
    words_t nw;
    logic [15:0] old0;
    int kind, d0;

    initial begin
        for (int i = 0; i < NW; i++) m_bank[i] = 16'h0000;

        tbl.push_back('{K_GOOD,   mk(16'h1234, 16'h5678, 16'h9ABC), 1, 0});
        tbl.push_back('{K_RESYNC, mk(16'h1111, 16'h2222, 16'h3333), 1, 0});
        tbl.push_back('{K_JUNK,   mk(16'hAAAA, 16'hBBBB, 16'hCCCC), 1, 0});
        tbl.push_back('{K_TMO,    mk(16'hDEAD, 16'hBEEF, 16'hF00D), 0, 1});
        tbl.push_back('{K_GOOD,   mk(16'h0001, 16'h0203, 16'h0405), 1, 0});
`ifdef FRAME_READ_CHECKSUM_EN
        tbl.push_back('{K_GOOD,   mk(16'h0102, 16'h0304, 16'h0506), 1, 0});
        tbl.push_back('{K_BADCK,  mk(16'h0102, 16'h0304, 16'h0506), 0, 1});
        tbl.push_back('{K_BADCK,  mk(16'h7777, 16'h8888, 16'h9999), 0, 1});
`endif

        // Reset state
        idle(3);
        check16("rst_done", {15'd0, frame_done}, 16'h0000);
        check16("rst_err", {15'd0, frame_err}, 16'h0000);
        check_reads("rst");
        rst_n = 1'b1;
        idle(2);

        for (int r = 0; r < tbl.size(); r++) begin
            apply_and_check($sformatf("tbl%0d", r), tbl[r].kind, tbl[r].words,
                            tbl[r].exp_done, tbl[r].exp_err);
        end

        // Commit latency and atomicity: addr0 holds the old value until the commit edge
        old0 = m_bank[0];
        nw = mk(16'($urandom), 16'($urandom), 16'($urandom));
        if (nw[0] == old0) nw[0] = ~old0;
        addr = '0;
        no_gap = 1'b1;
        send_byte(8'hBA);
        send_byte(8'h11);
        for (int i = 0; i < NW; i++) begin
            send_byte(nw[i][15:8]);
            #1 check16("atom_hi", data_out, old0);
            send_byte(nw[i][7:0]);
            #1 check16("atom_lo", data_out, old0);
        end
`ifdef FRAME_READ_CHECKSUM_EN
        send_byte(8'(nw[0][15:8] + nw[0][7:0] + nw[1][15:8] + nw[1][7:0] + nw[2][15:8] + nw[2][7:0]));
        #1;
`endif
        no_gap = 1'b0;
        check16("lat_done_early", {15'd0, frame_done}, 16'h0000);
        @(negedge clk);
        #1;
        check16("lat_done_pulse", {15'd0, frame_done}, 16'h0001);
        check16("lat_commit_rd", data_out, nw[0]);
        @(negedge clk);
        #1;
        check16("lat_done_drop", {15'd0, frame_done}, 16'h0000);
        model_apply(nw, 1, 0);
        $display("txn latency words=%h", nw);
        check_reads("lat");

        // Back-to-back frames: the second header starts in the commit cycle
        d0 = done_seen;
        no_gap = 1'b1;
        nw = mk(16'hC0DE, 16'hCAFE, 16'hFACE);
        send_byte(8'hBA); send_byte(8'h11); send_payload(nw, 1'b0);
        nw = mk(16'h4242, 16'h1357, 16'h2468);
        send_byte(8'hBA); send_byte(8'h11); send_payload(nw, 1'b0);
        no_gap = 1'b0;
        idle(3);
        #1;
        check_int("b2b_done", done_seen - d0, 2);
        model_apply(mk(16'hC0DE, 16'hCAFE, 16'hFACE), 1, 0);
        model_apply(nw, 1, 0);
        $display("txn back_to_back done=%0d", done_seen - d0);
        check_reads("b2b");

        // Reset mid-frame: partial frame dropped, bank and counters cleared
        d0 = done_seen;
        send_byte(8'hBA); send_byte(8'h11);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
        rst_n = 1'b0;
        for (int i = 0; i < NW; i++) m_bank[i] = 16'h0000;
        m_frames = 0;
        m_errs = 0;
        check_reads("midrst");
        idle(2);
        rst_n = 1'b1;
        idle(3);
        #1;
        check_int("midrst_done", done_seen - d0, 0);
        $display("txn reset_mid_frame");
        apply_and_check("postrst", K_GOOD, mk(16'h1234, 16'h5678, 16'h9ABC), 1, 0);

        // Randomized frames against the frame-level model
        for (int n = 0; n < 40; n++) begin
`ifdef FRAME_READ_CHECKSUM_EN
            kind = $urandom_range(0, 4);
`else
            kind = $urandom_range(0, 3);
`endif
            nw = mk(16'($urandom), 16'($urandom), 16'($urandom));
            apply_and_check($sformatf("rnd%0d", n), kind, nw,
                            (kind == K_TMO || kind == K_BADCK) ? 0 : 1,
                            (kind == K_TMO || kind == K_BADCK) ? 1 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
